// File: rtl/program_store.sv
// Loadable instruction store for the washing-controller processor: byte-serial host load, combinational fetch.
// Optional checksum output enabled by defining PROGRAM_STORE_CHECKSUM_EN.
module program_store #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] WAIT_WORD = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic        load_ready,
    input  logic        load_done,
    input  logic [7:0]  pc,
    output logic [31:0] instr,
    output logic        ena,
    output logic [8:0]  prog_len,
    output logic        overflow
`ifdef PROGRAM_STORE_CHECKSUM_EN
    ,output logic [7:0] checksum
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_LEN = 9'(DEPTH);

    logic [31:0]   mem_r [0:DEPTH-1];
    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic          ena_r;
    logic          load_ready_r;
    logic [AW-1:0] wr_ptr_r;
    logic [1:0]    byte_cnt_r;
    logic [23:0]   lanes_r;
    logic [8:0]    prog_len_r;
    logic          overflow_r;
    logic          accept_s;
    logic          full_s;
    logic          word_done_s;
    logic [31:0]   word_s;

    // Next-state decode; load_start outranks load_done in every state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_start) state_nxt_s = ST_LOAD;
                else            state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (load_start)     state_nxt_s = ST_LOAD;
                else if (load_done) state_nxt_s = ST_RUN;
                else                state_nxt_s = ST_LOAD;
            end
            ST_RUN: begin
                if (load_start) state_nxt_s = ST_LOAD;
                else            state_nxt_s = ST_RUN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign accept_s    = (state_r == ST_LOAD) && load_valid && load_ready_r && !load_start;
    assign full_s      = (prog_len_r == DEPTH_LEN);
    assign word_done_s = accept_s && !full_s && (byte_cnt_r == 2'd3);
    assign word_s      = {load_byte, lanes_r};

    // State register plus registered ena/load_ready decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ena_r        <= 1'b0;
            load_ready_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            ena_r        <= (state_nxt_s == ST_RUN);
            load_ready_r <= (state_nxt_s == ST_LOAD);
        end
    end

    // Byte assembly, write pointer, length and overflow tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            byte_cnt_r <= 2'd0;
            lanes_r    <= 24'd0;
            prog_len_r <= 9'd0;
            overflow_r <= 1'b0;
        end else if (load_start) begin
            wr_ptr_r   <= {AW{1'b0}};
            byte_cnt_r <= 2'd0;
            prog_len_r <= 9'd0;
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                if (full_s) begin
                    overflow_r <= 1'b1;
                end else if (byte_cnt_r == 2'd3) begin
                    wr_ptr_r   <= wr_ptr_r + AW'(1);
                    prog_len_r <= prog_len_r + 9'd1;
                    byte_cnt_r <= 2'd0;
                end else begin
                    case (byte_cnt_r)
                        2'd0:    lanes_r[7:0]   <= load_byte;
                        2'd1:    lanes_r[15:8]  <= load_byte;
                        2'd2:    lanes_r[23:16] <= load_byte;
                        default: lanes_r        <= lanes_r;
                    endcase
                    byte_cnt_r <= byte_cnt_r + 2'd1;
                end
            end
            // A trailing partial word is abandoned when the program ends.
            if ((state_r == ST_LOAD) && load_done) begin
                byte_cnt_r <= 2'd0;
            end
        end
    end

    // Instruction memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (word_done_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    // Zero-latency fetch; anything not loaded or outside RUN reads as a wait.
    always_comb begin
        instr = WAIT_WORD;
        if ((state_r == ST_RUN) && ({1'b0, pc} < prog_len_r)) begin
            instr = mem_r[pc[AW-1:0]];
        end else begin
            instr = WAIT_WORD;
        end
    end

    assign ena        = ena_r;
    assign load_ready = load_ready_r;
    assign prog_len   = prog_len_r;
    assign overflow   = overflow_r;

`ifdef PROGRAM_STORE_CHECKSUM_EN
    logic [7:0] checksum_r;

    function automatic logic [7:0] word_sum(input logic [31:0] w);
        return w[7:0] + w[15:8] + w[23:16] + w[31:24];
    endfunction

    // Running mod-256 sum of every byte committed to memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_r <= 8'd0;
        end else if (load_start) begin
            checksum_r <= 8'd0;
        end else if (word_done_s) begin
            checksum_r <= checksum_r + word_sum(word_s);
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign checksum = checksum_r;
`else
    // Checksum feature not built: no port and no accumulator.
`endif

endmodule

// File: tb/tb_program_store.sv
// Directed self-checking bench for program_store (DEPTH=4), with optional checksum checks.
module tb_program_store;
    localparam logic [31:0] WW = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic        load_done;
    logic [7:0]  pc;
    logic [31:0] instr;
    logic        ena;
    logic [8:0]  prog_len;
    logic        overflow;
`ifdef PROGRAM_STORE_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    int total = 0;
    int bad   = 0;

    program_store #(.DEPTH(4), .WAIT_WORD(WW)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
        .load_byte(load_byte), .load_ready(load_ready), .load_done(load_done),
        .pc(pc), .instr(instr), .ena(ena), .prog_len(prog_len), .overflow(overflow)
`ifdef PROGRAM_STORE_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    // Stimulus helpers: called at a negedge, hold inputs across one posedge.
    task automatic put_byte(input logic [7:0] b);
        load_valid = 1'b1; load_byte = b;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic pulse_done();
        load_done = 1'b1;
        @(negedge clk);
        load_done = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (ena !== 1'b0) begin bad++; $display("FAIL reset_ena got=%b exp=0", ena); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", load_ready); end
        total++; if (prog_len !== 9'd0) begin bad++; $display("FAIL reset_len got=%0d exp=0", prog_len); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        total++; if (instr !== WW) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr, WW); end
`ifdef PROGRAM_STORE_CHECKSUM_EN
        total++; if (checksum !== 8'h00) begin bad++; $display("FAIL reset_csum got=%h exp=00", checksum); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_ignores_done();
        load_valid = 1'b1; load_byte = 8'h55;
        pulse_done();
        load_valid = 1'b0;
        #1;
        total++; if (ena !== 1'b0) begin bad++; $display("FAIL idle_done_ena got=%b exp=0", ena); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b exp=0", load_ready); end
        total++; if (prog_len !== 9'd0) begin bad++; $display("FAIL idle_len got=%0d exp=0", prog_len); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        pulse_start();
        #1;
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", load_ready); end
        @(negedge clk);
        put_byte(8'h02); put_byte(8'h00); put_byte(8'h20); put_byte(8'h00);
        put_byte(8'h03); put_byte(8'h00); put_byte(8'h30); put_byte(8'h00);
        total++; if (prog_len !== 9'd2) begin bad++; $display("FAIL basic_len got=%0d exp=2", prog_len); end
        load_done = 1'b1;
        #1;
        total++; if (ena !== 1'b0) begin bad++; $display("FAIL basic_ena_early got=%b exp=0", ena); end
        @(negedge clk);
        load_done = 1'b0;
        #1;
        total++; if (ena !== 1'b1) begin bad++; $display("FAIL basic_ena got=%b exp=1", ena); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_run got=%b exp=0", load_ready); end
        pc = 8'd0; #1;
        total++; if (instr !== 32'h0020_0002) begin bad++; $display("FAIL basic_pc0 got=%h exp=00200002", instr); end
        pc = 8'd1; #1;
        total++; if (instr !== 32'h0030_0003) begin bad++; $display("FAIL basic_pc1 got=%h exp=00300003", instr); end
        pc = 8'd2; #1;
        total++; if (instr !== WW) begin bad++; $display("FAIL basic_pc2 got=%h exp=%h", instr, WW); end
        @(negedge clk);
    endtask

    task automatic test_reload_wait();
        pulse_start();
        for (int p = 0; p < 4; p++) begin
            pc = p[7:0]; #1;
            total++; if (instr !== WW) begin bad++; $display("FAIL reload_pc%0d got=%h exp=%h", p, instr, WW); end
        end
        #1;
        total++; if (ena !== 1'b0) begin bad++; $display("FAIL reload_ena got=%b exp=0", ena); end
        total++; if (prog_len !== 9'd0) begin bad++; $display("FAIL reload_len got=%0d exp=0", prog_len); end
        @(negedge clk);
    endtask

    task automatic test_partial();
        pulse_start();
        put_byte(8'h11); put_byte(8'h00); put_byte(8'hAB); put_byte(8'h00); put_byte(8'h11);
        pulse_done();
        #1;
        total++; if (prog_len !== 9'd1) begin bad++; $display("FAIL part_len got=%0d exp=1", prog_len); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL part_ovf got=%b exp=0", overflow); end
        pc = 8'd0; #1;
        total++; if (instr !== 32'h00AB_0011) begin bad++; $display("FAIL part_pc0 got=%h exp=00ab0011", instr); end
        pc = 8'd1; #1;
        total++; if (instr !== WW) begin bad++; $display("FAIL part_pc1 got=%h exp=%h", instr, WW); end
`ifdef PROGRAM_STORE_CHECKSUM_EN
        total++; if (checksum !== 8'hBC) begin bad++; $display("FAIL part_csum got=%h exp=bc", checksum); end
`endif
        @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [31:0] exp_w;
        pulse_start();
        for (int i = 1; i <= 16; i++) put_byte(i[7:0]);
        total++; if (prog_len !== 9'd4) begin bad++; $display("FAIL ovf_len16 got=%0d exp=4", prog_len); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow); end
        put_byte(8'd17);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL ovf_ready got=%b exp=1", load_ready); end
        for (int i = 18; i <= 20; i++) put_byte(i[7:0]);
        total++; if (prog_len !== 9'd4) begin bad++; $display("FAIL ovf_len got=%0d exp=4", prog_len); end
`ifdef PROGRAM_STORE_CHECKSUM_EN
        total++; if (checksum !== 8'h88) begin bad++; $display("FAIL ovf_csum got=%h exp=88", checksum); end
`endif
        pulse_done();
        for (int w = 0; w < 4; w++) begin
            exp_w = {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)};
            pc = w[7:0]; #1;
            total++; if (instr !== exp_w) begin bad++; $display("FAIL ovf_word%0d got=%h exp=%h", w, instr, exp_w); end
        end
        pc = 8'd4; #1;
        total++; if (instr !== WW) begin bad++; $display("FAIL ovf_pc4 got=%h exp=%h", instr, WW); end
        @(negedge clk);
    endtask

    task automatic test_done_with_byte();
        pulse_start();
        put_byte(8'h05); put_byte(8'h00); put_byte(8'h50);
        load_valid = 1'b1; load_byte = 8'h00; load_done = 1'b1;
        @(negedge clk);
        load_valid = 1'b0; load_done = 1'b0;
        pc = 8'd0; #1;
        total++; if (prog_len !== 9'd1) begin bad++; $display("FAIL sim_len got=%0d exp=1", prog_len); end
        total++; if (ena !== 1'b1) begin bad++; $display("FAIL sim_ena got=%b exp=1", ena); end
        total++; if (instr !== 32'h0050_0005) begin bad++; $display("FAIL sim_pc0 got=%h exp=00500005", instr); end
`ifdef PROGRAM_STORE_CHECKSUM_EN
        total++; if (checksum !== 8'h55) begin bad++; $display("FAIL sim_csum got=%h exp=55", checksum); end
`endif
        @(negedge clk);
    endtask

    task automatic test_start_done_run();
        load_start = 1'b1; load_done = 1'b1;
        @(negedge clk);
        load_start = 1'b0; load_done = 1'b0;
        pc = 8'd0; #1;
        total++; if (ena !== 1'b0) begin bad++; $display("FAIL sd_ena got=%b exp=0", ena); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL sd_ready got=%b exp=1", load_ready); end
        total++; if (prog_len !== 9'd0) begin bad++; $display("FAIL sd_len got=%0d exp=0", prog_len); end
        total++; if (instr !== WW) begin bad++; $display("FAIL sd_pc0 got=%h exp=%h", instr, WW); end
`ifdef PROGRAM_STORE_CHECKSUM_EN
        total++; if (checksum !== 8'h00) begin bad++; $display("FAIL sd_csum got=%h exp=00", checksum); end
`endif
        @(negedge clk);
    endtask

    task automatic test_start_with_byte();
        put_byte(8'h01); put_byte(8'h02); put_byte(8'h03);
        load_valid = 1'b1; load_byte = 8'h04; load_start = 1'b1;
        @(negedge clk);
        load_valid = 1'b0; load_start = 1'b0;
        put_byte(8'hA1); put_byte(8'h00); put_byte(8'h00); put_byte(8'h00);
        pulse_done();
        pc = 8'd0; #1;
        total++; if (prog_len !== 9'd1) begin bad++; $display("FAIL swb_len got=%0d exp=1", prog_len); end
        total++; if (instr !== 32'h0000_00A1) begin bad++; $display("FAIL swb_pc0 got=%h exp=000000a1", instr); end
        @(negedge clk);
    endtask

    task automatic test_reset_midload();
        pulse_start();
        for (int i = 0; i < 6; i++) put_byte(8'h10 + i[7:0]);
        total++; if (prog_len !== 9'd1) begin bad++; $display("FAIL rml_pre_len got=%0d exp=1", prog_len); end
        rst_n = 1'b0;
        #1;
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL rml_ready got=%b exp=0", load_ready); end
        total++; if (ena !== 1'b0) begin bad++; $display("FAIL rml_ena got=%b exp=0", ena); end
        total++; if (prog_len !== 9'd0) begin bad++; $display("FAIL rml_len got=%0d exp=0", prog_len); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_valid = 1'b1; load_byte = 8'h99;
        @(negedge clk);
        load_valid = 1'b0;
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL rml_idle got=%b exp=0", load_ready); end
    endtask

    initial begin
        rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_byte = 8'h00;
        load_done = 1'b0; pc = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        test_idle_ignores_done();
        test_basic();
        test_reload_wait();
        test_partial();
        test_overflow();
        test_done_with_byte();
        test_start_done_run();
        test_start_with_byte();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
